// File: rtl/exu_acc_arbiter.sv
`timescale 1ns/1ps
// exu_acc_arbiter: round-robin arbiter that time-shares one bf16->fp32 streaming
// accumulator between N_REQ vector requesters and buffers each tagged fp32 sum.
module exu_acc_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ-1:0]      req_last,
   input  logic [16*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  exu_enable,
   output logic                  exu_data_en,
   output logic [15:0]           exu_data,
   input  logic                  exu_data_en_o,
   input  logic [31:0]           exu_data_o,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [ID_W-1:0]       res_id,
   output logic [31:0]           res_data,
   output logic [CNT_W-1:0]      res_count,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2,
      S_RESULT = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [ID_W-1:0]  gnt_q, gnt_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             res_valid_q, res_valid_d;
   logic [ID_W-1:0]  res_id_q, res_id_d;
   logic [31:0]      res_data_q, res_data_d;
   logic [CNT_W-1:0] res_count_q, res_count_d;

   logic             win_found;
   logic [ID_W-1:0]  win_id;
   logic [ID_W-1:0]  idx;
   logic             can_grant;
   logic             accept;

   // First valid requester at or above the pointer, wrapping past N_REQ-1.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ID_W'((int'(ptr_q) + k) % N_REQ);
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   // The buffer slot is free now or is being popped this very cycle.
   assign can_grant = !res_valid_q || res_ready;
   assign accept    = (state_q == S_STREAM) && req_valid[gnt_q];

   // NOTE: every _d signal takes its hold value first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      res_valid_d = res_valid_q;
      res_id_d    = res_id_q;
      res_data_d  = res_data_q;
      res_count_d = res_count_q;

      if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (can_grant && win_found) begin
               gnt_d   = win_id;
               cnt_d   = '0;
               ptr_d   = (int'(win_id) == N_REQ - 1) ? '0 : win_id + ID_W'(1);
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (accept) begin
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (req_last[gnt_q]) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            state_d = S_RESULT;
         end
         S_RESULT: begin
            state_d = S_IDLE;
            // Only the strobe raised for this vector may load the buffer.
            if (exu_data_en_o) begin
               res_valid_d = 1'b1;
               res_data_d  = exu_data_o;
               res_id_d    = gnt_q;
               res_count_d = cnt_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      req_ready   = '0;
      exu_enable  = 1'b1;
      exu_data_en = 1'b0;
      exu_data    = '0;
      if (state_q == S_STREAM) begin
         req_ready[gnt_q] = 1'b1;
         exu_data_en      = 1'b1;
         exu_data         = req_data[int'(gnt_q) * 16 +: 16];
         // A stall freezes the accumulator; dropping data_en instead would end its vector.
         exu_enable       = req_valid[gnt_q];
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         gnt_q       <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_data_q  <= '0;
         res_count_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_data_q  <= res_data_d;
         res_count_q <= res_count_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res_data  = res_data_q;
   assign res_count = res_count_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/exu_acc_arbiter.md
# exu_acc_arbiter

Round-robin arbiter and sequencer that shares one bf16→fp32 streaming accumulator (the EX accumulate unit) between `N_REQ` vector requesters. Each requester streams a bf16 vector using valid/ready/last. The block:
- grants one requester at a time;
- drives the accumulator's enable, data-enable and data inputs so the vector forms one contiguous run;
- captures the fp32 sum into a one-entry output buffer tagged with the requester ID and element count.

It sits between the softmax/normalisation front-end requesters and the accumulator instance.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, at least 2.
- `ID_W`, 2: requester-ID width, equal to clog2(`N_REQ`).
- `CNT_W`, 8: element-counter width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; deassertion is synchronised externally.
- `req_valid`  in  `N_REQ`  element valid, one bit per requester.
- `req_last`  in  `N_REQ`  marks the final element of the vector.
- `req_data`  in  16×`N_REQ`  bf16 element; requester i uses bits [16i+15:16i].
- `req_ready`  out  `N_REQ`  element accepted; at most one bit high.
- `exu_enable`  out  1  accumulator clock-enable.
- `exu_data_en`  out  1  accumulator input valid.
- `exu_data`  out  16  bf16 to the accumulator.
- `exu_data_en_o`  in  1  accumulator result valid.
- `exu_data_o`  in  32  accumulator fp32 result.
- `res_valid`  out  1  result buffer full.
- `res_ready`  in  1  result consumer ready.
- `res_id`  out  `ID_W`  requester that owns the result.
- `res_data`  out  32  fp32 sum.
- `res_count`  out  `CNT_W`  number of elements summed; saturates at all-ones.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- **Reset values:** state IDLE; round-robin pointer 0, so requester 0 has highest priority first. All outputs are 0 except `exu_enable`, which is 1.
- **IDLE**
  - `exu_data_en`=0 and `exu_enable`=1.
  - A grant is issued only when `res_valid`=0, or when `res_valid`=1 and `res_ready`=1 in the same cycle.
  - The winner is the first i with `req_valid[i]`=1, searching from the pointer upward with wrap.
  - On grant: register `gnt`=i, clear the counter, set the pointer to i+1 (mod `N_REQ`), and go to STREAM.
- **STREAM**
  - `req_ready[gnt]`=1, `exu_data`=`req_data[gnt]`, `exu_data_en`=1.
  - `exu_enable`=`req_valid[gnt]`. When the requester stalls, the accumulator is frozen rather than fed a 0 data-enable, because a 0 data-enable would terminate its vector.
  - Each accepted element (valid and ready) increments the counter, saturating.
  - An accepted element with `req_last[gnt]`=1 moves the block to DRAIN.
- **DRAIN**
  - `exu_enable`=1 and `exu_data_en`=0. This 1→0 edge makes the accumulator register its sum.
  - No `req_ready` is asserted.
  - Next state is RESULT.
- **RESULT**
  - `exu_enable`=1 and `exu_data_en`=0.
  - `exu_data_en_o` is 1 in this cycle by construction.
  - On the clock edge: `res_data`←`exu_data_o`, `res_id`←`gnt`, `res_count`←counter, `res_valid`←1.
  - Next state is IDLE.
- **Result buffer:** `res_valid` clears on `res_valid`&`res_ready`. Contents are held while `res_ready` is low.
- **Stray result:** `exu_data_en_o`=1 outside RESULT is ignored.
- **Other requesters:** `req_valid` of non-granted requesters does not affect the active burst.
- **Reset mid-burst:** the burst is abandoned and the buffered result is dropped. The accumulator shares this reset, so no partial sum survives.

## Timing
- Grant decided in IDLE at cycle G.
- First element is presented in cycle G+1.
- A K-element burst with no stalls accepts its last element at G+K. DRAIN is G+K+1, RESULT is G+K+2, and `res_valid` is visible from G+K+3.
- Each requester stall cycle extends STREAM by 1 and leaves the sum unchanged.
- Minimum occupancy per vector is K+3 cycles. The next grant cannot occur before G+K+3.
- `req_ready` is combinational from the state and `gnt` only; it never depends on `req_valid`.

## Test plan
- **Single vector:** requester 1 sends 0x3F80, 0x4000, 0x4040 (last), no stalls -> `res_valid` rises 3 cycles after the last element with `res_data`=0x40C00000, `res_id`=1, `res_count`=3.
- **Stall mid-vector:** requester 0 sends 0x3F80, drops valid for 4 cycles, then sends 0x3F80 (last) -> `exu_enable` is 0 for exactly those 4 cycles and `res_data`=0x40000000, `res_count`=2.
- **Round-robin fairness:** all 4 requesters hold valid continuously with 1-element vectors -> grants are 0,1,2,3,0; each `res_id` matches its grant order.
- **Output backpressure:** `res_ready`=0 for 10 cycles while requester 2 is pending -> no grant and `req_ready`=0 throughout. When `res_ready` pulses, the grant occurs in the same cycle as the pop.
- **Single-element vector:** requester 3 sends 0xBF80 (last) -> `res_data`=0xBF800000, `res_count`=1.
- **Reset in STREAM:** reset asserted after 2 of 5 elements -> all outputs reach their reset values immediately; after release, a fresh vector sums correctly with no residue.
